npuarc_mmu_ntlb_pd1_ctrl: RTL and testbench
===========================================

# npuarc_mmu_ntlb_pd1_ctrl

Access controller for the MMU nTLB PD1 (data) single-port RAM. Arbitrates between the lookup read port, the refill write port and an invalidate-all sweep, and sequences the RAM power pins (deep sleep, shutdown, light sleep). Sits between the nTLB lookup/refill logic and `npuarc_mmu_ntlb_pd1_ram`, driving every RAM pin.

## Interface
- `RAM_DATA_WIDTH`, 32, PD1 entry width
- `RAM_ADDR_WIDTH`, 7, entry index width
- `RAM_DEPTH`, 128, entries swept by invalidate-all
- `WR_MAX_WAIT`, 4, cycles a pending write may lose to lookups before it is forced through
- `WAKE_CYCLES`, 3, cycles held in WAKE after ds/sd release
- `IDLE_LS_CYCLES`, 8, idle cycles before light sleep (only with `NPUARC_NTLB_PD1_LS_EN`)

Ports:
- `clk`  in  1  clock
- `rst_a`  in  1  reset; **one clock; reset is synchronous and active-high**
- `lkup_req` / `lkup_addr`  in  1 / AW  lookup read request and index
- `lkup_gnt`  out  1  lookup accepted this cycle
- `lkup_rvalid` / `lkup_rdata`  out  1 / DW  read data, one cycle after `lkup_gnt`
- `wr_req` / `wr_addr` / `wr_data`  in  1 / AW / DW  refill write; held until `wr_ack`
- `wr_ack`  out  1  write performed this cycle
- `inv_all_req`  in  1  pulse; zero every entry
- `inv_busy` / `inv_done`  out  1 / 1  sweep active; one-cycle pulse at sweep end
- `pwr_ds_req` / `pwr_sd_req`  in  1 / 1  deep-sleep / shutdown request, level
- `pwr_ack`  out  1  RAM is in ds/sd
- `ram_cs`, `ram_we`, `ram_addr`, `ram_din`  out  1/1/AW/DW  RAM access pins
- `ram_dout`  in  DW  RAM read data
- `ram_ds`, `ram_sd`, `ram_ls`  out  1  RAM power pins

## Operation
- States: RUN, INV, SLEEP, WAKE. During reset every output is 0. In the first cycle after reset release the block enters INV, because RAM contents are unknown at power-up.
- INV: sweep index counts 0..RAM_DEPTH-1. Each cycle it writes zeros with `cs=we=1`. `inv_busy=1` and all grants are 0. After the last index: `inv_done` pulses and the block goes to RUN. An `inv_all_req` during INV is ignored.
- RUN priority, highest first:
  - `inv_all_req`: enters INV next cycle. Any write is not acked that cycle.
  - forced write: `wr_req` has lost `WR_MAX_WAIT` consecutive cycles.
  - lookup.
  - write.
- Exactly one of `lkup_gnt`/`wr_ack` per cycle. The wait counter clears on `wr_ack`.
- `lkup_rdata` is `ram_dout` passed through. It is 0 when `lkup_rvalid=0`.
- Read after write to the same index on the next cycle returns the new data.
- `pwr_ds_req`/`pwr_sd_req` is taken in RUN only, and only when the current cycle issues no access. Next state is SLEEP.
  - SLEEP: `ram_ds`/`ram_sd` follow the requests, `ram_cs=0`, `pwr_ack=1`, no grants. `sd` wins if both are requested.
- When both requests drop, the block goes to WAKE. It holds for `WAKE_CYCLES` cycles with power pins 0 and `pwr_ack=0`, then returns to RUN.
- An `inv_all_req` arriving in SLEEP/WAKE is latched and executed on return to RUN.
- Reset mid-sweep or mid-sleep: the state is abandoned and the sweep restarts from index 0 after release.

## Timing
- Lookup: request in cycle N, `lkup_gnt` in N (combinational), `lkup_rvalid` in N+1.
- Write: `wr_ack` in the cycle the RAM write pins are driven.
- Sweep: `RAM_DEPTH` cycles, with `inv_done` in the cycle after the last write.
- Exit from SLEEP to the first grant: `WAKE_CYCLES`+1 cycles after the requests drop.
- All state and counters are registered. `ram_*` access pins are combinational from the state and arbitration result.

## Configuration
- `NPUARC_NTLB_PD1_LS_EN` defined:
  - In RUN, an idle counter counts cycles with `ram_cs=0`. When it reaches `IDLE_LS_CYCLES`, `ram_ls=1`.
  - Any request, or entry to INV or SLEEP, clears `ram_ls` in that cycle and withholds grants for that one cycle, a 1-cycle wake penalty.
- Undefined: `ram_ls` is tied 0 and there is no idle counter or penalty.

## Structure
- Shared package `npuarc_mmu_ntlb_pkg`: state encoding enum and power-pin struct.
- One natural sub-module, `npuarc_mmu_ntlb_pd1_pwr_seq`. It owns SLEEP/WAKE/LS sequencing and the wake/idle counters, and reports `pwr_block` to the arbiter.

## Test plan
- Reset, then idle → `inv_busy`=1 for 128 cycles with `ram_addr` 0..127, `ram_we=1`, `ram_din=0`; `inv_done` pulses once; a lookup afterwards reads 0.
- Write addr 5 = 0xDEADBEEF, lookup addr 5 next cycle → `lkup_rvalid`=1 with 0xDEADBEEF one cycle after `lkup_gnt`.
- `lkup_req` held high continuously with `wr_req` pending → `wr_ack` in the 5th cycle (after 4 lost), a lookup denied that cycle, and lookups resuming after.
- `pwr_sd_req`=1 in RUN idle → `ram_sd`=1 and `pwr_ack`=1 next cycle. Pulse `inv_all_req` while asleep. Drop `pwr_sd_req` → 3 WAKE cycles, then a full sweep before any grant.
- Assert `rst_a` at sweep index 60 → after release the sweep restarts at 0 and runs all 128 entries.
- With `NPUARC_NTLB_PD1_LS_EN`: 8 idle cycles → `ram_ls`=1. Then `lkup_req` → `ram_ls`=0 with no grant that cycle, `lkup_gnt` the following cycle.

Source files
------------

// File: rtl/npuarc_mmu_ntlb_pkg.sv
// Shared types for the MMU nTLB PD1 RAM access controller: controller state
// encoding and the RAM power-pin bundle.
package npuarc_mmu_ntlb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_INV   = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } pd1_state_e;

    typedef struct packed {
        logic ds;
        logic sd;
        logic ls;
    } pd1_pwr_pins_t;

endpackage

// File: rtl/npuarc_mmu_ntlb_pd1_pwr_seq.sv
// PD1 RAM power sequencer: drives ds/sd/ls pins, times the WAKE window and
// tells the arbiter when grants must be withheld.
// Optional light-sleep support is built when NPUARC_NTLB_PD1_LS_EN is defined.
module npuarc_mmu_ntlb_pd1_pwr_seq
    import npuarc_mmu_ntlb_pkg::*;
#(
    parameter int unsigned WAKE_CYCLES    = 3,
    parameter int unsigned IDLE_LS_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst_a,
    input  pd1_state_e    state,
    input  logic          pwr_ds_req,
    input  logic          pwr_sd_req,
    input  logic          any_req,
    input  logic          ram_cs,
    output pd1_pwr_pins_t pwr_pins,
    output logic          pwr_ack,
    output logic          sleep_exit,
    output logic          wake_done,
    output logic          pwr_block
);

    localparam int unsigned WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    logic           active;
    logic           in_run;
    logic           in_sleep;
    logic           in_wake;
    logic           ls_on;
    logic [WCW-1:0] wake_cnt;

    assign active     = !rst_a;
    assign in_run     = active && (state == ST_RUN);
    assign in_sleep   = active && (state == ST_SLEEP);
    assign in_wake    = active && (state == ST_WAKE);
    assign pwr_ack    = in_sleep;
    assign sleep_exit = in_sleep && !pwr_ds_req && !pwr_sd_req;
    assign wake_done  = in_wake && (wake_cnt == WCW'(WAKE_CYCLES - 1));

    // Count cycles spent in WAKE; restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst_a || !in_wake) begin
            wake_cnt <= '0;
        end else begin
            wake_cnt <= wake_cnt + 1'b1;
        end
    end

`ifdef NPUARC_NTLB_PD1_LS_EN
    localparam int unsigned ICW = (IDLE_LS_CYCLES > 1) ? $clog2(IDLE_LS_CYCLES) : 1;

    logic [ICW-1:0] idle_cnt;
    logic           ls_q;

    // Idle counter arms light sleep; any request or leaving RUN disarms it.
    always_ff @(posedge clk) begin
        if (rst_a || !in_run || any_req) begin
            idle_cnt <= '0;
            ls_q     <= 1'b0;
        end else if (!ram_cs && !ls_q) begin
            if (idle_cnt == ICW'(IDLE_LS_CYCLES - 1)) begin
                ls_q <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // A request arriving while in light sleep drops ls at once and costs one
    // grant-free cycle while the array wakes.
    assign ls_on     = ls_q && in_run && !any_req;
    assign pwr_block = ls_q && in_run && any_req;
`else
    logic unused_ls_in;

    assign unused_ls_in = &{1'b0, any_req, ram_cs, (IDLE_LS_CYCLES == 0)};
    assign ls_on        = 1'b0;
    assign pwr_block    = 1'b0;
`endif

    // Power pins: ds/sd only in SLEEP, shutdown wins over deep sleep.
    always_comb begin
        pwr_pins    = '0;
        pwr_pins.ls = ls_on;
        if (in_sleep) begin
            pwr_pins.sd = pwr_sd_req;
            pwr_pins.ds = pwr_ds_req && !pwr_sd_req;
        end
    end

endmodule

// File: rtl/npuarc_mmu_ntlb_pd1_ctrl.sv
// MMU nTLB PD1 RAM access controller: arbitrates lookup reads, refill writes
// and the invalidate-all sweep onto the single RAM port, and hands power
// sequencing to npuarc_mmu_ntlb_pd1_pwr_seq.
// Optional light sleep: define NPUARC_NTLB_PD1_LS_EN.
module npuarc_mmu_ntlb_pd1_ctrl
    import npuarc_mmu_ntlb_pkg::*;
#(
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 7,
    parameter int unsigned RAM_DEPTH      = 128,
    parameter int unsigned WR_MAX_WAIT    = 4,
    parameter int unsigned WAKE_CYCLES    = 3,
    parameter int unsigned IDLE_LS_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_a,
    input  logic                      lkup_req,
    input  logic [RAM_ADDR_WIDTH-1:0] lkup_addr,
    output logic                      lkup_gnt,
    output logic                      lkup_rvalid,
    output logic [RAM_DATA_WIDTH-1:0] lkup_rdata,
    input  logic                      wr_req,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_ack,
    input  logic                      inv_all_req,
    output logic                      inv_busy,
    output logic                      inv_done,
    input  logic                      pwr_ds_req,
    input  logic                      pwr_sd_req,
    output logic                      pwr_ack,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_din,
    input  logic [RAM_DATA_WIDTH-1:0] ram_dout,
    output logic                      ram_ds,
    output logic                      ram_sd,
    output logic                      ram_ls
);

    localparam int unsigned WWW = $clog2(WR_MAX_WAIT + 1);

    pd1_state_e                state;
    logic [RAM_ADDR_WIDTH-1:0] inv_idx;
    logic [WWW-1:0]            wr_wait;
    logic                      inv_latched;
    logic                      rvalid_q;
    logic                      inv_done_q;

    logic                      active;
    logic                      in_run;
    logic                      inv_pend;
    logic                      any_req;
    logic                      go_inv;
    logic                      go_sleep;
    logic                      sleep_exit;
    logic                      wake_done;
    logic                      pwr_block;
    pd1_pwr_pins_t             pwr_pins;

    assign active   = !rst_a;
    assign in_run   = active && (state == ST_RUN);
    assign inv_pend = inv_all_req || inv_latched;
    assign any_req  = lkup_req || wr_req || inv_pend || pwr_ds_req || pwr_sd_req;

    npuarc_mmu_ntlb_pd1_pwr_seq #(
        .WAKE_CYCLES    (WAKE_CYCLES),
        .IDLE_LS_CYCLES (IDLE_LS_CYCLES)
    ) u_pwr_seq (
        .clk        (clk),
        .rst_a      (rst_a),
        .state      (state),
        .pwr_ds_req (pwr_ds_req),
        .pwr_sd_req (pwr_sd_req),
        .any_req    (any_req),
        .ram_cs     (ram_cs),
        .pwr_pins   (pwr_pins),
        .pwr_ack    (pwr_ack),
        .sleep_exit (sleep_exit),
        .wake_done  (wake_done),
        .pwr_block  (pwr_block)
    );

    assign ram_ds = pwr_pins.ds;
    assign ram_sd = pwr_pins.sd;
    assign ram_ls = pwr_pins.ls;

    // RUN arbitration: invalidate, starved write, lookup, write; sleep entry
    // only on a cycle that issues no access.
    always_comb begin
        lkup_gnt = 1'b0;
        wr_ack   = 1'b0;
        go_inv   = 1'b0;
        go_sleep = 1'b0;
        if (in_run) begin
            if (inv_pend) begin
                go_inv = 1'b1;
            end else if (!pwr_block) begin
                if (wr_req && (wr_wait == WWW'(WR_MAX_WAIT))) begin
                    wr_ack = 1'b1;
                end else if (lkup_req) begin
                    lkup_gnt = 1'b1;
                end else if (wr_req) begin
                    wr_ack = 1'b1;
                end
            end
            if (!inv_pend && !lkup_gnt && !wr_ack && (pwr_ds_req || pwr_sd_req)) begin
                go_sleep = 1'b1;
            end
        end
    end

    // RAM access pins follow the state and the arbitration result directly.
    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (active && (state == ST_INV)) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = inv_idx;
        end else if (lkup_gnt) begin
            ram_cs   = 1'b1;
            ram_addr = lkup_addr;
        end else if (wr_ack) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_din  = wr_data;
        end
    end

    assign inv_busy    = active && (state == ST_INV);
    assign inv_done    = active && inv_done_q;
    assign lkup_rvalid = active && rvalid_q;
    assign lkup_rdata  = lkup_rvalid ? ram_dout : '0;

    // Controller FSM; reset lands in INV so the array is cleared at power-up.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state       <= ST_INV;
            inv_idx     <= '0;
            inv_latched <= 1'b0;
            rvalid_q    <= 1'b0;
            inv_done_q  <= 1'b0;
        end else begin
            rvalid_q   <= lkup_gnt;
            inv_done_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (go_inv) begin
                        state       <= ST_INV;
                        inv_idx     <= '0;
                        inv_latched <= 1'b0;
                    end else if (go_sleep) begin
                        state <= ST_SLEEP;
                    end
                end
                ST_INV: begin
                    inv_idx <= inv_idx + 1'b1;
                    if (inv_idx == RAM_ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        state      <= ST_RUN;
                        inv_done_q <= 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (inv_all_req) begin
                        inv_latched <= 1'b1;
                    end
                    if (sleep_exit) begin
                        state <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (inv_all_req) begin
                        inv_latched <= 1'b1;
                    end
                    if (wake_done) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_INV;
            endcase
        end
    end

    // Consecutive lookup wins against a pending write; cleared on ack.
    always_ff @(posedge clk) begin
        if (rst_a || wr_ack || !wr_req) begin
            wr_wait <= '0;
        end else if (lkup_gnt) begin
            wr_wait <= wr_wait + 1'b1;
        end
    end

endmodule

// File: tb/tb_npuarc_mmu_ntlb_pd1_ctrl.sv
// Self-checking bench for npuarc_mmu_ntlb_pd1_ctrl (default build, light
// sleep disabled): directed scenarios followed by random traffic, all checked
// every cycle against a behavioural model.
module tb_npuarc_mmu_ntlb_pd1_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int MAXW  = 4;
    localparam int WAKE  = 3;

    logic          clk = 1'b0;
    logic          rst_a;
    logic          lkup_req;
    logic [AW-1:0] lkup_addr;
    logic          lkup_gnt;
    logic          lkup_rvalid;
    logic [DW-1:0] lkup_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          inv_all_req;
    logic          inv_busy;
    logic          inv_done;
    logic          pwr_ds_req;
    logic          pwr_sd_req;
    logic          pwr_ack;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_ds;
    logic          ram_sd;
    logic          ram_ls;

    always #5 clk = ~clk;

    npuarc_mmu_ntlb_pd1_ctrl #(
        .RAM_DATA_WIDTH (DW),
        .RAM_ADDR_WIDTH (AW),
        .RAM_DEPTH      (DEPTH),
        .WR_MAX_WAIT    (MAXW),
        .WAKE_CYCLES    (WAKE),
        .IDLE_LS_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .lkup_req    (lkup_req),
        .lkup_addr   (lkup_addr),
        .lkup_gnt    (lkup_gnt),
        .lkup_rvalid (lkup_rvalid),
        .lkup_rdata  (lkup_rdata),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .inv_all_req (inv_all_req),
        .inv_busy    (inv_busy),
        .inv_done    (inv_done),
        .pwr_ds_req  (pwr_ds_req),
        .pwr_sd_req  (pwr_sd_req),
        .pwr_ack     (pwr_ack),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_ds      (ram_ds),
        .ram_sd      (ram_sd),
        .ram_ls      (ram_ls)
    );

    // Synchronous single-port RAM standing in for npuarc_mmu_ntlb_pd1_ram.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining sweep entries, remaining wake cycles, an
    // asleep flag, a pending-invalidate flag, the write loss count and a
    // shadow copy of the array.
    int            sweep_left;
    int            wake_left;
    int            lost;
    bit            asleep;
    bit            inv_pend;
    bit            rd_pend;
    bit            nxt_rd;
    bit            done_next;
    bit            last_ack;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] mem_m [DEPTH];

    logic          e_gnt, e_ack, e_busy, e_done, e_rvalid, e_cs, e_we;
    logic [DW-1:0] e_rdata, e_din;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_pwr;

    always @(negedge clk) begin
        e_gnt = 0; e_ack = 0; e_busy = 0; e_done = 0; e_rvalid = 0;
        e_cs = 0; e_we = 0; e_rdata = '0; e_din = '0; e_addr = '0; e_pwr = '0;
        nxt_rd = 0;
        if (rst_a) begin
            sweep_left = DEPTH; wake_left = 0; lost = 0;
            asleep = 0; inv_pend = 0; done_next = 0;
        end else begin
            e_done    = done_next;
            done_next = 0;
            e_rvalid  = rd_pend;
            if (rd_pend) e_rdata = rd_val;
            if (sweep_left > 0) begin
                e_busy = 1; e_cs = 1; e_we = 1;
                e_addr = AW'(DEPTH - sweep_left);
                mem_m[DEPTH - sweep_left] = '0;
                sweep_left--;
                if (sweep_left == 0) done_next = 1;
            end else if (asleep) begin
                e_pwr = {pwr_ds_req && !pwr_sd_req, pwr_sd_req, 1'b0, 1'b1};
                if (inv_all_req) inv_pend = 1;
                if (!pwr_ds_req && !pwr_sd_req) begin
                    asleep    = 0;
                    wake_left = WAKE;
                end
            end else if (wake_left > 0) begin
                if (inv_all_req) inv_pend = 1;
                wake_left--;
            end else if (inv_all_req || inv_pend) begin
                sweep_left = DEPTH;
                inv_pend   = 0;
            end else begin
                if (wr_req && lost >= MAXW) e_ack = 1;
                else if (lkup_req)          e_gnt = 1;
                else if (wr_req)            e_ack = 1;
                if (e_gnt) begin
                    e_cs   = 1;
                    e_addr = lkup_addr;
                    nxt_rd = 1;
                    rd_val = mem_m[lkup_addr];
                    if (wr_req) lost++;
                end
                if (e_ack) begin
                    e_cs = 1; e_we = 1;
                    e_addr = wr_addr;
                    e_din  = wr_data;
                    mem_m[wr_addr] = wr_data;
                    lost = 0;
                end
                if (!e_gnt && !e_ack && (pwr_ds_req || pwr_sd_req)) asleep = 1;
            end
            if (!wr_req) lost = 0;
        end
        rd_pend  = nxt_rd;
        last_ack = e_ack;

        check("lkup_gnt",    64'(lkup_gnt),    64'(e_gnt));
        check("wr_ack",      64'(wr_ack),      64'(e_ack));
        check("inv_busy",    64'(inv_busy),    64'(e_busy));
        check("inv_done",    64'(inv_done),    64'(e_done));
        check("lkup_rvalid", 64'(lkup_rvalid), 64'(e_rvalid));
        check("lkup_rdata",  64'(lkup_rdata),  64'(e_rdata));
        check("ram_cs",      64'(ram_cs),      64'(e_cs));
        check("ram_we",      64'(ram_we),      64'(e_we));
        check("ram_addr",    64'(ram_addr),    64'(e_addr));
        check("ram_din",     64'(ram_din),     64'(e_din));
        check("pwr",         64'({ram_ds, ram_sd, ram_ls, pwr_ack}), 64'(e_pwr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pwr_hold;

    initial begin
        rst_a = 1; lkup_req = 0; lkup_addr = '0; wr_req = 0; wr_addr = '0;
        wr_data = '0; inv_all_req = 0; pwr_ds_req = 0; pwr_sd_req = 0;
        repeat (3) tick();
        rst_a = 0;
        repeat (132) tick();

        // Refill then immediate lookup of the same entry.
        wr_req = 1; wr_addr = 7'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_req = 0; lkup_req = 1; lkup_addr = 7'd5;
        tick();
        lkup_req = 0;
        repeat (2) tick();

        // Write starved by back-to-back lookups.
        wr_req = 1; wr_addr = 7'd9; wr_data = 32'h1234_5678;
        lkup_req = 1; lkup_addr = 7'd9;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_ack) wr_req = 0;
        end
        lkup_req = 0; wr_req = 0;
        tick();

        // Shutdown with an invalidate pulse while asleep, then wake.
        pwr_sd_req = 1;
        repeat (4) tick();
        inv_all_req = 1;
        tick();
        inv_all_req = 0;
        repeat (2) tick();
        pwr_sd_req = 0; lkup_req = 1; lkup_addr = 7'd9;
        repeat (140) tick();
        lkup_req = 0;

        // Reset part-way through a sweep.
        inv_all_req = 1;
        tick();
        inv_all_req = 0;
        repeat (61) tick();
        rst_a = 1;
        repeat (2) tick();
        rst_a = 0;
        repeat (132) tick();

        // Random traffic.
        pwr_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            lkup_req  = ($urandom_range(0, 99) < 60);
            lkup_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            if (!wr_req || last_ack) begin
                wr_req  = ($urandom_range(0, 99) < 40);
                wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wr_data = $urandom;
            end
            inv_all_req = ($urandom_range(0, 999) < 4);
            if (pwr_hold > 0) begin
                pwr_hold--;
            end else begin
                pwr_ds_req = 0; pwr_sd_req = 0;
                if ($urandom_range(0, 99) < 3) begin
                    pwr_ds_req = 1'($urandom);
                    pwr_sd_req = 1'($urandom);
                    pwr_hold   = $urandom_range(1, 6);
                end
            end
            rst_a = ($urandom_range(0, 999) < 2);
            tick();
        end
        rst_a = 0; lkup_req = 0; wr_req = 0; inv_all_req = 0;
        pwr_ds_req = 0; pwr_sd_req = 0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
